// File: rtl/sdft_bin_scanner.sv
// Scans every sdft frequency bin once per start strobe, streams squared magnitudes
// with their bin index, and reports the largest bin of each completed frame.
module sdft_bin_scanner #(
  parameter int unsigned freq_bins  = 16,
  parameter int unsigned addr_width = 4,
  parameter int unsigned bin_width  = 16,
  parameter int unsigned mag_width  = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic [addr_width-1:0]       bin_addr,
  input  logic signed [bin_width-1:0] bin_real,
  input  logic signed [bin_width-1:0] bin_imag,
  output logic                        busy,
  output logic                        start_dropped,
  output logic                        mag_valid,
  output logic [mag_width-1:0]        mag,
  output logic [addr_width-1:0]       mag_bin,
  output logic                        mag_last,
  output logic                        peak_valid,
  output logic [addr_width-1:0]       peak_bin,
  output logic [mag_width-1:0]        peak_mag
);

  localparam logic [addr_width-1:0] last_addr = addr_width'(freq_bins - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t                 state;
  logic [1:0]             drain_cnt;
  logic                   rd_valid;
  logic [addr_width-1:0]  rd_bin;
  logic [mag_width-1:0]   run_max;
  logic [addr_width-1:0]  run_bin;

  logic signed [mag_width-1:0] re_ext, im_ext, re_sq, im_sq;
  logic [mag_width-1:0]        mag_c;
  logic                        take_c;
  logic [mag_width-1:0]        best_mag_c;
  logic [addr_width-1:0]       best_bin_c;

  // Squares are non-negative, so the sum is reinterpreted as unsigned; the
  // worst case (both parts at the most negative value) is exactly 2^(mag_width-1).
  always_comb begin
    re_ext = mag_width'(bin_real);
    im_ext = mag_width'(bin_imag);
    re_sq  = re_ext * re_ext;
    im_sq  = im_ext * im_ext;
    mag_c  = $unsigned(re_sq) + $unsigned(im_sq);
  end

  // Bin 0 reseeds the running max; later bins replace it only when strictly larger.
  always_comb begin
    take_c     = (mag_bin == '0) || (mag > run_max);
    best_mag_c = take_c ? mag : run_max;
    best_bin_c = take_c ? mag_bin : run_bin;
  end

  // Frame sequencer: bin_addr doubles as the read counter and holds after the scan.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      drain_cnt     <= '0;
      bin_addr      <= '0;
      busy          <= 1'b0;
      start_dropped <= 1'b0;
      rd_valid      <= 1'b0;
      rd_bin        <= '0;
    end else begin
      start_dropped <= start && (state != IDLE);
      rd_valid      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= READ;
            bin_addr <= '0;
            busy     <= 1'b1;
          end
        end
        READ: begin
          rd_valid <= 1'b1;
          rd_bin   <= bin_addr;
          if (bin_addr == last_addr) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            bin_addr <= bin_addr + addr_width'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd2) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Magnitude stage, aligned with read data returning one cycle after bin_addr.
  always_ff @(posedge clk) begin
    if (reset) begin
      mag_valid <= 1'b0;
      mag       <= '0;
      mag_bin   <= '0;
      mag_last  <= 1'b0;
    end else begin
      mag_valid <= rd_valid;
      mag_last  <= rd_valid && (rd_bin == last_addr);
      if (rd_valid) begin
        mag     <= mag_c;
        mag_bin <= rd_bin;
      end
    end
  end

  // Peak tracker; the last bin's magnitude is folded in as the peak is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_max    <= '0;
      run_bin    <= '0;
      peak_valid <= 1'b0;
      peak_bin   <= '0;
      peak_mag   <= '0;
    end else begin
      peak_valid <= 1'b0;
      if (mag_valid) begin
        run_max <= best_mag_c;
        run_bin <= best_bin_c;
        if (mag_last) begin
          peak_valid <= 1'b1;
          peak_mag   <= best_mag_c;
          peak_bin   <= best_bin_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdft_bin_scanner.sv
// Scoreboard bench for sdft_bin_scanner: a synchronous bin memory model feeds the
// DUT, stimulus queues expected magnitudes/peaks, and a monitor checks them.
module tb_sdft_bin_scanner;

  localparam int unsigned FB = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned BW = 16;
  localparam int unsigned MW = 32;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic [AW-1:0]        bin_addr;
  logic signed [BW-1:0] bin_real = '0;
  logic signed [BW-1:0] bin_imag = '0;
  logic                 busy, start_dropped, mag_valid, mag_last, peak_valid;
  logic [MW-1:0]        mag, peak_mag;
  logic [AW-1:0]        mag_bin, peak_bin;

  sdft_bin_scanner #(
    .freq_bins(FB), .addr_width(AW), .bin_width(BW), .mag_width(MW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bin_addr(bin_addr),
    .bin_real(bin_real), .bin_imag(bin_imag), .busy(busy),
    .start_dropped(start_dropped), .mag_valid(mag_valid), .mag(mag),
    .mag_bin(mag_bin), .mag_last(mag_last), .peak_valid(peak_valid),
    .peak_bin(peak_bin), .peak_mag(peak_mag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int mem_re [FB];
  int mem_im [FB];
  always @(posedge clk) begin
    bin_real <= BW'(mem_re[bin_addr]);
    bin_imag <= BW'(mem_im[bin_addr]);
  end

  typedef struct {
    logic [MW-1:0] mag;
    logic [AW-1:0] bin;
    logic          last;
    int            cyc;
  } mag_exp_t;

  typedef struct {
    logic [AW-1:0] bin;
    logic [MW-1:0] mag;
    int            cyc;
  } peak_exp_t;

  mag_exp_t  mag_q[$];
  peak_exp_t peak_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [MW-1:0] mag_model(input int re, input int im);
    longint s;
    s = longint'(re) * longint'(re) + longint'(im) * longint'(im);
    return MW'(s);
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < int'(FB); i++) begin
      mem_re[i] = 0;
      mem_im[i] = 0;
    end
  endtask

  // Expected stream for a frame whose start is sampled in cycle t.
  task automatic push_frame(input int t, input int pbin, input logic [MW-1:0] pmag);
    mag_exp_t  m;
    peak_exp_t p;
    for (int k = 0; k < int'(FB); k++) begin
      m.mag  = mag_model(mem_re[k], mem_im[k]);
      m.bin  = AW'(k);
      m.last = (k == int'(FB) - 1);
      m.cyc  = t + 3 + k;
      mag_q.push_back(m);
    end
    p.bin = AW'(pbin);
    p.mag = pmag;
    p.cyc = t + 3 + int'(FB);
    peak_q.push_back(p);
  endtask

  task automatic to_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_start_dropped"}, start_dropped, 0);
    check({tag, "_mag_valid"}, mag_valid, 0);
    check({tag, "_mag"}, mag, 0);
    check({tag, "_mag_bin"}, mag_bin, 0);
    check({tag, "_mag_last"}, mag_last, 0);
    check({tag, "_peak_valid"}, peak_valid, 0);
    check({tag, "_peak_bin"}, peak_bin, 0);
    check({tag, "_peak_mag"}, peak_mag, 0);
    check({tag, "_bin_addr"}, bin_addr, 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a magnitude or a peak.
  always @(posedge clk) begin
    mag_exp_t  e;
    peak_exp_t p;
    #1;
    if (!reset && mag_valid) begin
      if (mag_q.size() == 0) fail_event("spurious mag_valid");
      else begin
        e = mag_q.pop_front();
        check("mag", mag, e.mag);
        check("mag_bin", mag_bin, e.bin);
        check("mag_last", mag_last, e.last);
        check("mag_cycle", cyc, e.cyc);
      end
    end
    if (!reset && peak_valid) begin
      if (peak_q.size() == 0) fail_event("spurious peak_valid");
      else begin
        p = peak_q.pop_front();
        check("peak_bin", peak_bin, p.bin);
        check("peak_mag", peak_mag, p.mag);
        check("peak_cycle", cyc, p.cyc);
      end
    end
  end

  initial begin
    int t;
    int bad;
    clear_mem();
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;                   // start together with reset: reset must win
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    start = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy !== 1'b0 || mag_valid !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 0);

    // Single tone in bin 3
    mem_re[3] = 3; mem_im[3] = -4;
    t = cyc; start = 1'b1; push_frame(t, 3, 32'd25);
    @(negedge clk); start = 1'b0;
    check("tone_busy_start", busy, 1);
    to_cycle(t + 19); check("tone_busy_peak", busy, 1);
    to_cycle(t + 20); check("tone_busy_done", busy, 0);
    check("tone_addr_hold", bin_addr, 4'hF);

    // Tie between bins 2 and 5 resolves to the lower index
    clear_mem();
    mem_re[2] = 6;  mem_im[2] = 8;
    mem_re[5] = -8; mem_im[5] = -6;
    to_cycle(cyc + 2);
    t = cyc; start = 1'b1; push_frame(t, 2, 32'd100);
    @(negedge clk); start = 1'b0;
    to_cycle(t + 21);

    // Most negative value on both parts
    clear_mem();
    mem_re[2] = 6; mem_im[2] = 8;
    mem_re[9] = -32768; mem_im[9] = -32768;
    t = cyc; start = 1'b1; push_frame(t, 9, 32'h8000_0000);
    @(negedge clk); start = 1'b0;
    to_cycle(t + 21);

    // Starts while busy are dropped; the first one after peak_valid is taken
    clear_mem();
    mem_re[3] = 3; mem_im[3] = -4;
    mem_re[7] = 1; mem_im[7] = 2;
    t = cyc; start = 1'b1; push_frame(t, 3, 32'd25);
    @(negedge clk); start = 1'b0;
    to_cycle(t + 5); start = 1'b1;
    to_cycle(t + 6); start = 1'b0;
    check("drop_mid", start_dropped, 1);
    to_cycle(t + 7); check("drop_clear", start_dropped, 0);
    to_cycle(t + 19); start = 1'b1;
    check("drop_peak_busy", busy, 1);
    to_cycle(t + 20);
    check("drop_at_peak", start_dropped, 1);
    push_frame(t + 20, 3, 32'd25);
    to_cycle(t + 21); start = 1'b0;
    check("restart_busy", busy, 1);
    to_cycle(t + 42);

    // Reset in the middle of a frame
    t = cyc; start = 1'b1; push_frame(t, 3, 32'd25);
    @(negedge clk); start = 1'b0;
    to_cycle(t + 10);
    reset = 1'b1;
    mag_q.delete();
    peak_q.delete();
    to_cycle(t + 11);
    check_all_zero("midreset");
    reset = 1'b0;
    to_cycle(t + 15); start = 1'b1; push_frame(t + 15, 3, 32'd25);
    @(negedge clk); start = 1'b0;
    to_cycle(t + 37);

    // Back-to-back frames; frame 2 peak is smaller than frame 1 peak
    clear_mem();
    mem_re[3] = 30; mem_im[3] = 40;
    t = cyc; start = 1'b1; push_frame(t, 3, 32'd2500);
    @(negedge clk); start = 1'b0;
    to_cycle(t + 20);
    clear_mem();
    mem_re[15] = 2; mem_im[15] = 0;
    start = 1'b1; push_frame(t + 20, 15, 32'd4);
    @(negedge clk); start = 1'b0;
    to_cycle(t + 43);

    bad = 0;
    while ((mag_q.size() != 0 || peak_q.size() != 0) && bad < 50) begin
      @(negedge clk);
      bad++;
    end
    if (mag_q.size() != 0) fail_event("timeout: mag expectations left");
    if (peak_q.size() != 0) fail_event("timeout: peak expectations left");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
